// File: rtl/key_pkg.sv
// Shared types and constants for the key debouncer.
// The state encoding and key polarity helper are used by key_debounce and its bench.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    DOWN       = 2'd2,
    REL_WAIT   = 2'd3
  } key_state_t;

  // 50 MHz clock: 20 ms debounce window and 1 s long-press window
  localparam int DEBOUNCE_20MS = 1_000_000;
  localparam int LONG_1S       = 50_000_000;

  // Short window for simulation builds
  localparam int DEBOUNCE_SIM  = 10;

  // Map the raw pin level onto pressed = 1
  function automatic logic key_normalise(input logic raw, input logic active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin entering the clk domain.
// RST_VAL sets the level both flops assume during reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture; reset loads the inactive level so no false edge appears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Key debouncer: synchronises key_in, filters bounce and emits press/release strobes.
// Optional long-press strobe is built when KEY_LONG_PRESS_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = DEBOUNCE_20MS,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int LONG_CYC       = LONG_1S
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic POL_LOW   = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic RST_LEVEL = POL_LOW;

  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYC must be at least 2");
  end
  if (LONG_CYC < 1) begin : g_bad_long
    $error("key_debounce: LONG_CYC must be at least 1");
  end

  logic       key_sync_s;
  logic       pressed_s;
  key_state_t state_r;
  logic [CNT_W-1:0] cnt_r;

  sync_2ff #(
    .RST_VAL (RST_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_sync_s)
  );

  assign pressed_s = key_normalise(key_sync_s, POL_LOW);

  // Debounce FSM with registered level and strobes; strobes default low each cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r     <= '0;
          key_level <= 1'b0;
          if (pressed_s) begin
            state_r <= PRESS_WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!pressed_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_MAX) begin
            state_r   <= DOWN;
            cnt_r     <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DOWN: begin
          cnt_r     <= '0;
          key_level <= 1'b1;
          if (!pressed_s) begin
            state_r <= REL_WAIT;
          end else begin
            state_r <= DOWN;
          end
        end
        REL_WAIT: begin
          if (pressed_s) begin
            state_r <= DOWN;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_MAX) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          key_level <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CYC + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYC);
  localparam logic [LONG_W-1:0] LONG_HIT = LONG_W'(LONG_CYC - 1);

  logic [LONG_W-1:0] long_cnt_r;

  // Hold timer: counts in DOWN, freezes across a release bounce, clears otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_cnt_r <= '0;
      key_long   <= 1'b0;
    end else begin
      key_long <= 1'b0;
      case (state_r)
        DOWN: begin
          if (long_cnt_r == LONG_HIT) begin
            long_cnt_r <= LONG_MAX;
            key_long   <= 1'b1;
          end else if (long_cnt_r != LONG_MAX) begin
            long_cnt_r <= long_cnt_r + LONG_W'(1);
          end else begin
            long_cnt_r <= long_cnt_r;
          end
        end
        REL_WAIT: long_cnt_r <= long_cnt_r;
        default:  long_cnt_r <= '0;
      endcase
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: table of hold segments plus latency sequences.
// Long-press checks follow KEY_LONG_PRESS_EN as defined for the build.
module tb_key_debounce;
  import key_pkg::*;

  localparam int DEB  = 10;
  localparam int LONG = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic key_level, key_press, key_release, key_long;

  int n_checks = 0;
  int n_pass   = 0;

  key_debounce #(
    .DEBOUNCE_CYC   (DEB),
    .KEY_ACTIVE_LOW (1),
    .LONG_CYC       (LONG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #10 clk = ~clk;

  typedef struct {
    string name;
    logic  key;
    int    cycles;
    int    exp_press;
    int    exp_rel;
    logic  exp_level;
  } seg_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (key_press && key_release) check("press_release_overlap", 1, 0);
  endtask

  // Drive a new key level and time the resulting strobe from the first edge
  task automatic timed_edge(input logic k, input logic want_press, input string name);
    int first = -1;
    int seen  = 0;
    key_in = k;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (want_press ? key_press : key_release) begin
        seen++;
        if (first < 0) first = i;
      end
    end
    check({name, "_latency"}, first, DEB + 3);
    check({name, "_count"}, seen, 1);
  endtask

  seg_t segs[7];

  initial begin
    int np, nr, nl, t_press, t_long;

    segs[0] = '{"rel_glitch5",    1'b1, 5,  0, 0, 1'b1};
    segs[1] = '{"held_again",     1'b0, 20, 0, 0, 1'b1};
    segs[2] = '{"rel_glitch9",    1'b1, 9,  0, 0, 1'b1};
    segs[3] = '{"held_after9",    1'b0, 20, 0, 0, 1'b1};
    segs[4] = '{"real_release",   1'b1, 20, 0, 1, 1'b0};
    segs[5] = '{"press_glitch9",  1'b0, 9,  0, 0, 1'b0};
    segs[6] = '{"idle_after9",    1'b1, 20, 0, 0, 1'b0};

    // 1. Reset
    key_in = 1'b1;
    rst_n  = 1'b0;
    repeat (10) tick();
    check("rst_level",   int'(key_level),   0);
    check("rst_press",   int'(key_press),   0);
    check("rst_release", int'(key_release), 0);
    check("rst_long",    int'(key_long),    0);
    check("rst_state",   int'(dut.state_r), int'(IDLE));
    rst_n = 1'b1;
    np = 0;
    repeat (15) begin tick(); if (key_press) np++; end
    check("idle_no_press", np, 0);

    // 2. Clean press and release
    timed_edge(1'b0, 1'b1, "clean_press");
    check("clean_press_level", int'(key_level), 1);
    timed_edge(1'b1, 1'b0, "clean_release");
    check("clean_release_level", int'(key_level), 0);

    // 3. Bounce every 3 cycles, then settle pressed
    np = 0;
    for (int j = 0; j < 40; j++) begin
      if (j % 3 == 0) key_in = ~key_in;
      tick();
      if (key_press) np++;
    end
    check("bounce_no_press", np, 0);
    timed_edge(1'b0, 1'b1, "bounce_press");

    // 4. Segment table: glitches and real transitions from the held state
    foreach (segs[s]) begin
      np = 0; nr = 0;
      key_in = segs[s].key;
      for (int i = 0; i < segs[s].cycles; i++) begin
        tick();
        if (key_press)   np++;
        if (key_release) nr++;
      end
      check({segs[s].name, "_press"},   np, segs[s].exp_press);
      check({segs[s].name, "_release"}, nr, segs[s].exp_rel);
      check({segs[s].name, "_level"},   int'(key_level), int'(segs[s].exp_level));
    end

    // 5. Reset during PRESS_WAIT with the key still held
    key_in = 1'b0;
    np = 0;
    repeat (8) begin tick(); if (key_press) np++; end
    check("midcount_state", int'(dut.state_r), int'(PRESS_WAIT));
    rst_n = 1'b0;
    repeat (5) begin tick(); if (key_press) np++; end
    check("midcount_no_press", np, 0);
    check("midcount_rst_state", int'(dut.state_r), int'(IDLE));
    check("midcount_rst_level", int'(key_level), 0);
    rst_n = 1'b1;
    timed_edge(1'b0, 1'b1, "after_rst_press");
    timed_edge(1'b1, 1'b0, "after_rst_release");

    // 6. Long hold of 200 cycles
    key_in = 1'b0;
    np = 0; nl = 0; t_press = -1; t_long = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (key_press) begin np++; if (t_press < 0) t_press = i; end
      if (key_long)  begin nl++; if (t_long  < 0) t_long  = i; end
    end
    check("hold_press_count", np, 1);
    check("hold_press_latency", t_press, DEB + 3);
`ifdef KEY_LONG_PRESS_EN
    check("hold_long_count", nl, 1);
    check("hold_long_delay", t_long - t_press, LONG);
`else
    check("hold_long_absent", nl, 0);
`endif
    timed_edge(1'b1, 1'b0, "long_release");
    check("final_level", int'(key_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces a raw mechanical key input and turns each clean press into a single-cycle strobe. Its `key_press` output drives the `en` input of the pulse-generator stage directly downstream. The block also exports the debounced level and a release strobe for other consumers. The input is asynchronous to `clk` and is synchronised internally.

## Interface
- `DEBOUNCE_CYC`, default 1_000_000: number of consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range ≥ 2.
- `KEY_ACTIVE_LOW`, default 1: 1 means the key is pressed when `key_in` = 0; 0 means pressed when `key_in` = 1.
- `LONG_CYC`, default 50_000_000: held-cycles threshold for the long-press strobe; used only with `KEY_LONG_PRESS_EN`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `key_in` in 1: raw key pin, asynchronous, may bounce.
- `key_level` out 1: debounced state, 1 = pressed.
- `key_press` out 1: one-cycle strobe on an accepted press. Feeds the pulse stage's `en`.
- `key_release` out 1: one-cycle strobe on an accepted release.
- `key_long` out 1: one-cycle strobe when a press has been held for `LONG_CYC` cycles. Tied to 0 when the feature is compiled out.

## Operation
- Two-flop synchroniser on `key_in`, then polarity normalisation to `pressed` (1 = pressed).
- Four-state FSM:
  - IDLE: released and stable.
  - PRESS_WAIT: candidate press, counting.
  - DOWN: pressed and stable.
  - REL_WAIT: candidate release, counting.
- IDLE → PRESS_WAIT when `pressed` = 1; `cnt` cleared to 0.
- PRESS_WAIT:
  - `pressed` = 0 → IDLE, `cnt` = 0. A bounce restarts the count; no strobe.
  - `pressed` = 1 and `cnt` = `DEBOUNCE_CYC`-1 → DOWN; `key_level` ← 1; `key_press` pulses for 1 cycle.
  - Otherwise `cnt` increments.
- DOWN → REL_WAIT when `pressed` = 0; `cnt` cleared.
- REL_WAIT:
  - `pressed` = 1 → DOWN with no strobe.
  - Count complete → IDLE; `key_level` ← 0; `key_release` pulses.
  - Otherwise `cnt` increments.
- `cnt` width is $clog2(`DEBOUNCE_CYC`). It never wraps: it saturates at the compare value and is cleared on every state entry.
- `key_press` and `key_release` are never high in the same cycle. No strobe is repeated without an intervening opposite transition.

## Timing
- All outputs are registered.
- Reset (while `rst_n` = 0 at a `clk` edge):
  - State = IDLE, `cnt` = 0.
  - Synchroniser flops = released level.
  - `key_level` = 0, `key_press` = 0, `key_release` = 0, `key_long` = 0.
- Latency: `key_in` held stable from edge k → `key_press` high during cycle k+`DEBOUNCE_CYC`+3. Breakdown: 2 synchroniser + 1 FSM entry + `DEBOUNCE_CYC` count. Release latency is identical.
- A glitch shorter than `DEBOUNCE_CYC` cycles, after synchronisation, produces no output change.
- Reset asserted mid-count aborts the count with no strobe. After reset is released, a key already held is re-detected as a new press with full latency.
- Strobe width is exactly 1 cycle regardless of hold time.

## Configuration
- `KEY_LONG_PRESS_EN` defined:
  - A second counter runs only while in DOWN and saturates at `LONG_CYC`.
  - `key_long` pulses once when it reaches `LONG_CYC`-1, i.e. `LONG_CYC` cycles after the `key_press` cycle.
  - The counter clears on leaving DOWN and on reset.
  - A bounce in REL_WAIT that returns to DOWN does not clear it.
- `KEY_LONG_PRESS_EN` not defined: no long counter is built and `key_long` is constant 0.

## Structure
- Shared package `key_pkg`:
  - FSM state typedef: IDLE, PRESS_WAIT, DOWN, REL_WAIT.
  - Default 50 MHz timing constants for 20 ms and 1 s.
  - Simulation-override constant DEBOUNCE_SIM = 10.
- One sub-module: `sync_2ff` (parameterised reset value). It is reused wherever an asynchronous pin enters the `clk` domain.

## Test plan
Bench conditions: `CYCLE` = 20 ns, `DEBOUNCE_CYC` = 10, `LONG_CYC` = 100, `KEY_ACTIVE_LOW` = 1.
1. Reset: hold `rst_n` = 0 for 10 cycles with `key_in` = 1 → all outputs 0, FSM in IDLE.
2. Clean press: `key_in` 1→0 and held → `key_press` high for exactly 1 cycle, 13 cycles after the edge; `key_level` = 1 thereafter.
3. Bounce: toggle `key_in` every 3 cycles for 40 cycles, then hold 0 → exactly one `key_press`, 13 cycles after the final edge.
4. Release glitch: with the key held, pulse `key_in` to 1 for 5 cycles → no `key_release`; `key_level` stays 1.
5. Reset mid-count: assert `rst_n` = 0 at cycle 6 of PRESS_WAIT with the key still held → no strobe during reset; one `key_press` 13 cycles after `rst_n` rises.
6. Long press (`KEY_LONG_PRESS_EN`): hold the key for 200 cycles → one `key_press`, one `key_long` 100 cycles later, then one `key_release` 13 cycles after the release edge.
